// File: rtl/dmem_responder.sv
// Single-port data-memory responder for a MEM stage: IDLE -> WAIT -> RESP handshake.
// Optional macro DMEM_ALIGN_CHECK_EN rejects word-misaligned addresses.
module dmem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  input  logic        rsp_ready
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic          enter_resp;
  logic          op_wr;
  logic [31:0]   op_addr;
  logic [31:0]   op_wdata;
  logic          range_err;
  logic          align_err;
  logic          op_err;
  logic [AW-1:0] op_idx;
  logic          mem_we;

  // With zero wait states RESP is entered on the acceptance edge itself,
  // so the operation must come straight from the request inputs.
  assign op_wr    = (state_q == ST_IDLE) ? req_write : wr_q;
  assign op_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
  assign op_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;

  assign range_err = (op_addr[31:2] >= 30'(DEPTH));
`ifdef DMEM_ALIGN_CHECK_EN
  assign align_err = (op_addr[1:0] != 2'b00);
`else
  assign align_err = &{1'b0, op_addr[1:0]};
`endif
  assign op_err = range_err | align_err;
  assign op_idx = op_addr[AW+1:2];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    enter_resp = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          wr_d    = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            enter_resp = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_CYCLES);
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          enter_resp = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
          rdata_d = 32'h0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    if (enter_resp) begin
      state_d = ST_RESP;
      err_d   = op_err;
      rdata_d = (op_err || op_wr) ? 32'h0 : mem[op_idx];
    end
  end

  assign mem_we = enter_resp && op_wr && !op_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is never reset; the rst_n gate keeps a write from landing while reset is held.
  always_ff @(posedge clk) begin
    if (mem_we && rst_n) begin
      mem[op_idx] <= op_wdata;
    end
  end

  assign req_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus pushes expected responses, a monitor checks them.
module tb_dmem_responder;

  localparam int DEPTH       = 64;
  localparam int WAIT_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_ready = 1'b1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t sb[$];

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .rsp_ready (rsp_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Monitor: latency on the rising edge of rsp_valid, data/err on each handshake.
  // The FSM enters RESP on the edge WAIT_CYCLES after the acceptance edge
  // (WAIT_CYCLES+1 edges counting the acceptance edge itself).
  logic prev_v = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (rsp_valid && !prev_v) begin
        if (sb.size() == 0) fail_now("rsp_without_request");
        else chk("latency", 32'(cyc - sb[0].acc), 32'(WAIT_CYCLES));
      end
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_response");
        end else begin
          exp_t e;
          e = sb.pop_front();
          $display("txn rsp rdata=%h err=%0d exp_rdata=%h exp_err=%0d", rsp_rdata, rsp_err, e.rdata, e.err);
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
        end
      end
      prev_v = rsp_valid;
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] er, input logic ee);
    int t;
    t = 0;
    while (!req_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!req_ready) fail_now("req_ready_wait");
    $display("txn req write=%0d addr=%h wdata=%h", w, a, d);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk); #1;
    sb.push_back('{er, ee, cyc});
    // Scramble the bus after acceptance; the DUT must use captured values.
    req_valid = 1'b0;
    req_write = ~w;
    req_addr  = 32'hFFFF_FFFC;
    req_wdata = ~d;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 60) begin
      @(posedge clk); #1;
      t++;
    end
    if (sb.size() != 0) begin
      fail_now("response_wait");
      sb.delete();
    end
  endtask

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] er, input logic ee);
    issue(w, a, d, er, ee);
    drain();
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", {31'h0, req_ready}, 32'h1);
    chk("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("reset_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    xfer(1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
    xfer(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    xfer(1'b0, 32'h100, 32'h0, 32'h0, 1'b1);
    xfer(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    xfer(1'b1, 32'hFC, 32'hA5A5_A5A5, 32'h0, 1'b0);
    xfer(1'b0, 32'hFC, 32'h0, 32'hA5A5_A5A5, 1'b0);
    xfer(1'b1, 32'h104, 32'h5555_AAAA, 32'h0, 1'b1);
    xfer(1'b1, 32'hFFFF_FFF0, 32'h7777_7777, 32'h0, 1'b1);
    xfer(1'b1, 32'h0, 32'h0BAD_F00D, 32'h0, 1'b0);
    xfer(1'b0, 32'h0, 32'h0, 32'h0BAD_F00D, 1'b0);
    xfer(1'b1, 32'h14, 32'h1111_2222, 32'h0, 1'b0);
    xfer(1'b1, 32'h14, 32'h3333_4444, 32'h0, 1'b0);
    xfer(1'b0, 32'h14, 32'h0, 32'h3333_4444, 1'b0);
    xfer(1'b0, 32'hFC, 32'h0, 32'hA5A5_A5A5, 1'b0);

    // Stall in RESP with stray request pulses that must be ignored.
    rsp_ready = 1'b0;
    issue(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
    t = 0;
    while (!rsp_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!rsp_valid) fail_now("stall_rsp_wait");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_rsp_valid", {31'h0, rsp_valid}, 32'h1);
      chk("stall_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
      chk("stall_req_ready", {31'h0, req_ready}, 32'h0);
      @(posedge clk); #1;
      req_valid = (i % 2 == 0) && (i < 4);
      req_write = 1'b1;
      req_addr  = 32'h10;
      req_wdata = 32'hBAD0_BAD0;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    drain();
    xfer(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Reset while a write is still in WAIT.
    xfer(1'b1, 32'h20, 32'h0, 32'h0, 1'b0);
    issue(1'b1, 32'h20, 32'h1234_5678, 32'h0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_req_ready", {31'h0, req_ready}, 32'h1);
    chk("midreset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("midreset_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("midreset_rsp_rdata", rsp_rdata, 32'h0);
    sb.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(1'b0, 32'h20, 32'h0, 32'h0, 1'b0);

`ifdef DMEM_ALIGN_CHECK_EN
    xfer(1'b0, 32'h12, 32'h0, 32'h0, 1'b1);
`else
    xfer(1'b0, 32'h12, 32'h0, 32'hDEAD_BEEF, 1'b0);
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("final_idle_req_ready", {31'h0, req_ready}, 32'h1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
